// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter: round-robin arbiter sharing one N-byte RS-232
// transmit serializer among R requesters.
// Ports: clk, reset (sync, active-high), req[R], req_data[R*N*n],
//   grant[R], ack[R], err, busy, tx_start, tx_data[N*n], tx_done.
// Optional: define RS232_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
module rs232_tx_arbiter #(
   parameter int N       = 8,
   parameter int n       = 8,
   parameter int R       = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [R-1:0]     req,
   input  logic [R*N*n-1:0] req_data,
   output logic [R-1:0]     grant,
   output logic [R-1:0]     ack,
   output logic             err,
   output logic             busy,
   output logic             tx_start,
   output logic [N*n-1:0]   tx_data,
   input  logic             tx_done
);

   localparam int FW = N * n;
   localparam int PW = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic            found;
   logic [PW-1:0]   win;
   logic [R-1:0]    win_oh;
   logic [FW-1:0]   win_data;
   logic [PW-1:0]   ptr_next;
   int              idx;

   // Scan ptr, ptr+1, ... modulo R; first set req bit wins.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      win_oh   = '0;
      win_data = '0;
      idx      = 0;
      for (int k = 0; k < R; k++) begin
         idx = int'(ptr) + k;
         if (idx >= R) idx = idx - R;
         if (!found && req[PW'(idx)]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
      if (found) win_oh[win] = 1'b1;
      for (int k = 0; k < R; k++) begin
         if (PW'(k) == win) win_data = req_data[k*FW +: FW];
      end
   end

   assign ptr_next = (owner == PW'(R - 1)) ? '0 : owner + 1'b1;

`ifdef RS232_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         grant    <= '0;
         ack      <= '0;
         err      <= 1'b0;
         busy     <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         cnt      <= '0;
      end else begin
         ack      <= '0;
         err      <= 1'b0;
         tx_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  state    <= START;
                  owner    <= win;
                  grant    <= win_oh;
                  tx_data  <= win_data;
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            START: begin
               state <= WAIT;
               cnt   <= '0;
            end
            WAIT: begin
               // tx_done wins over a simultaneous terminal count.
               if (tx_done) begin
                  state <= DONE;
                  ack   <= grant;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state <= DONE;
                  ack   <= grant;
                  err   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
               ptr   <= ptr_next;
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign err = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         grant    <= '0;
         ack      <= '0;
         busy     <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         ack      <= '0;
         tx_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  state    <= START;
                  owner    <= win;
                  grant    <= win_oh;
                  tx_data  <= win_data;
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            START: state <= WAIT;
            WAIT: begin
               if (tx_done) begin
                  state <= DONE;
                  ack   <= grant;
               end
            end
            DONE: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
               ptr   <= ptr_next;
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb_rs232_tx_arbiter: directed-vector bench for rs232_tx_arbiter
// (R=4, N=8, n=8, TIMEOUT=16).
module tb_rs232_tx_arbiter;

   localparam int N  = 8;
   localparam int n  = 8;
   localparam int R  = 4;
   localparam int FW = N * n;

   logic             clk = 1'b0;
   logic             reset;
   logic [R-1:0]     req;
   logic [R*FW-1:0]  req_data;
   logic [R-1:0]     grant;
   logic [R-1:0]     ack;
   logic             err;
   logic             busy;
   logic             tx_start;
   logic [FW-1:0]    tx_data;
   logic             tx_done;

   int n_vec = 0;
   int n_bad = 0;

   logic [63:0] d0 = 64'h1111_0000_AAAA_0000;
   logic [63:0] d1 = 64'h2222_3333_4444_5555;
   logic [63:0] d2 = 64'hA5A5_0123_4567_89EF;
   logic [63:0] d3 = 64'hDEAD_BEEF_CAFE_F00D;

   rs232_tx_arbiter #(
      .N(N), .n(n), .R(R), .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .req_data(req_data),
      .grant(grant),
      .ack(ack),
      .err(err),
      .busy(busy),
      .tx_start(tx_start),
      .tx_data(tx_data),
      .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bounded wait for the tx_start strobe; leaves us in the START cycle.
   task automatic wait_start(input string tag);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (tx_start) break;
      end
      chk(tag, {63'd0, tx_start}, 64'd1);
   endtask

   // Full transfer with req already applied; tx_done dly cycles after START.
   task automatic run_xfer(input string tag, input logic [3:0] exp_g,
                           input logic [63:0] exp_d, input int dly,
                           input bit drop);
      wait_start({tag, "_start"});
      chk({tag, "_grant"}, {60'd0, grant}, {60'd0, exp_g});
      chk({tag, "_data"}, tx_data, exp_d);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         if (i == 0) chk({tag, "_pulse"}, {63'd0, tx_start}, 64'd0);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk({tag, "_ack"}, {60'd0, ack}, {60'd0, exp_g});
      chk({tag, "_err"}, {63'd0, err}, 64'd0);
      if (drop) req = req & ~exp_g;
      @(negedge clk);
      chk({tag, "_ack_off"}, {60'd0, ack}, 64'd0);
      chk({tag, "_idle_grant"}, {60'd0, grant}, 64'd0);
   endtask

   initial begin
      reset    = 1'b1;
      req      = '0;
      tx_done  = 1'b0;
      req_data = {d3, d2, d1, d0};
      repeat (2) @(negedge clk);
      chk("rst_grant", {60'd0, grant}, 64'd0);
      chk("rst_ack", {60'd0, ack}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_start", {63'd0, tx_start}, 64'd0);
      chk("rst_data", tx_data, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single requester on index 2; ptr becomes 3.
      req = 4'b0100;
      run_xfer("single", 4'b0100, d2, 10, 1'b1);
      // ptr=3 makes index 3 beat index 0.
      req = 4'b1001;
      run_xfer("ptr3", 4'b1000, d3, 2, 1'b1);

      // Contention from ptr=0 with all requests held.
      req = 4'b1111;
      run_xfer("rr0", 4'b0001, d0, 1, 1'b0);
      run_xfer("rr1", 4'b0010, d1, 3, 1'b0);
      run_xfer("rr2", 4'b0100, d2, 1, 1'b0);
      run_xfer("rr3", 4'b1000, d3, 2, 1'b0);
      run_xfer("rr4", 4'b0001, d0, 1, 1'b1);
      req = '0;
      @(negedge clk);

      // ptr=1 -> grant 2 -> ptr=3, then wrap and skip.
      req = 4'b0100;
      run_xfer("pre_wrap", 4'b0100, d2, 1, 1'b1);
      req = 4'b0101;
      run_xfer("wrap0", 4'b0001, d0, 2, 1'b1);
      run_xfer("wrap2", 4'b0100, d2, 2, 1'b1);
      req = '0;
      @(negedge clk);

      // Spurious tx_done in IDLE, then in START; ptr=3, req on 1.
      tx_done = 1'b1;
      @(negedge clk);
      chk("spur_idle_busy", {63'd0, busy}, 64'd0);
      req = 4'b0010;
      @(negedge clk);
      chk("spur_start", {63'd0, tx_start}, 64'd1);
      chk("spur_grant", {60'd0, grant}, 64'h2);
      @(negedge clk);
      tx_done = 1'b0;
      req_data[FW +: FW] = 64'h0BAD_0BAD_0BAD_0BAD;
      req = '0;
      repeat (3) @(negedge clk);
      chk("spur_wait_busy", {63'd0, busy}, 64'd1);
      chk("spur_wait_ack", {60'd0, ack}, 64'd0);
      chk("spur_data_hold", tx_data, d1);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("drop_ack", {60'd0, ack}, 64'h2);
      @(negedge clk);
      chk("drop_idle", {63'd0, busy}, 64'd0);
      req_data = {d3, d2, d1, d0};

      // Reset mid-WAIT; ptr is 2 beforehand.
      req = 4'b1000;
      wait_start("rstw_start");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req   = '0;
      chk("rstw_grant", {60'd0, grant}, 64'd0);
      chk("rstw_ack", {60'd0, ack}, 64'd0);
      chk("rstw_busy", {63'd0, busy}, 64'd0);
      chk("rstw_data", tx_data, 64'd0);
      @(negedge clk);
      chk("rstw_no_ack", {60'd0, ack}, 64'd0);
      req = 4'b0110;
      run_xfer("post_rst", 4'b0010, d1, 2, 1'b1);
      req = '0;
      @(negedge clk);

`ifdef RS232_ARB_TIMEOUT_EN
      req = 4'b0100;
      wait_start("to_start");
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 0 || i == 15)
            chk("to_no_ack", {60'd0, ack}, 64'd0);
      end
      @(negedge clk);
      req = '0;
      chk("to_ack", {60'd0, ack}, 64'h4);
      chk("to_err", {63'd0, err}, 64'd1);
      @(negedge clk);
      chk("to_busy", {63'd0, busy}, 64'd0);
      chk("to_err_off", {63'd0, err}, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Round-robin arbiter that shares one N-byte RS-232 transmit serializer among R requesters. It grants one requester at a time and latches that requester's N*n-bit frame onto the serializer data input. It issues a one-cycle start strobe, waits for the serializer's done pulse, and then acknowledges the requester. It sits between the system-side frame producers and the `Rs232_Tx_nbytes`-class transmitter, and runs in the same clock domain.

## Interface
Parameters:
- N, 8, bytes per frame
- n, 8, bits per byte
- R, 4, number of requesters (2..8)
- TIMEOUT, 4096, cycles allowed in WAIT before abort (used only when RS232_ARB_TIMEOUT_EN is defined)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  R  per-requester request level; held high until its ack
- req_data  input  R*N*n  frame of requester i at bits [(i+1)*N*n-1 : i*N*n]
- grant  output  R  one-hot; marks the owner of the current transfer
- ack  output  R  one-cycle completion pulse to the owner
- err  output  1  one-cycle pulse, coincident with ack, on timeout abort
- busy  output  1  high in every state except IDLE
- tx_start  output  1  one-cycle start strobe to the serializer
- tx_data  output  N*n  registered frame to the serializer
- tx_done  input  1  serializer completion pulse

## Operation
- FSM states:
  - IDLE: if any req bit is set, select the winner by round-robin, then go to START. Otherwise stay in IDLE.
  - START: tx_start=1 for this cycle only. Go to WAIT.
  - WAIT: on tx_done=1, go to DONE. Otherwise stay in WAIT (timeout exception under Configuration).
  - DONE: ack[owner]=1, then go to IDLE.
- Round-robin selection:
  - Priority pointer ptr (log2 R bits) names the highest-priority index.
  - The winner is the first set req bit scanning ptr, ptr+1, …, wrapping modulo R.
  - In DONE, ptr is updated to owner+1 modulo R.
- Capture on leaving IDLE:
  - grant is set to the winner's one-hot code.
  - tx_data is loaded from the winner's req_data slice.
  - Both hold unchanged through START, WAIT and DONE.
  - grant clears on entry to IDLE. tx_data retains its last value.
- Requester behaviour during a transfer:
  - Dropping req after grant does not abort; the transfer completes and ack still pulses.
  - Changing req_data after grant has no effect.
- tx_done is honoured only in WAIT. A tx_done in IDLE, START or DONE is ignored.
- Reset values: state=IDLE, ptr=0, grant=0, ack=0, err=0, busy=0, tx_start=0, tx_data=0.
- Reset asserted mid-transfer returns all of the above to reset values on the next edge. No ack is issued. The serializer shares the same reset.

## Timing
- All outputs are registered.
- Sequence for a request winning in IDLE at edge t:
  - From edge t+1: grant, tx_data, busy=1, and tx_start=1 for one cycle (START).
  - From edge t+2: WAIT.
  - tx_done sampled at edge k puts the block in DONE after edge k, with ack high for that one cycle.
  - IDLE follows after edge k+1.
- Fastest turnaround: tx_done in the first WAIT cycle gives req→ack of 4 cycles.
- There is at least one IDLE cycle between consecutive transfers. Back-to-back tx_start pulses are therefore at least 4 cycles apart.
- Simultaneous requests are resolved in that same IDLE cycle by the ptr rule only.

## Configuration
- RS232_ARB_TIMEOUT_EN defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without tx_done, the FSM goes to DONE with ack[owner]=1 and err=1 for that one cycle. ptr advances normally.
  - tx_done and terminal count in the same cycle count as success (err=0).
- Not defined:
  - There is no counter. WAIT persists until tx_done or reset.
  - err is tied to 0.

## Test plan
- Single requester: R=4, req=4'b0100, req_data slice 2=64'hA5A5_0123_4567_89EF, tx_done 10 cycles after tx_start.
  - Expect grant=4'b0100 and tx_data equal to that value, with a single tx_start pulse.
  - Expect ack=4'b0100 one cycle after tx_done.
  - Expect ptr=3.
- Contention: req=4'b1111 held continuously, each transfer completed.
  - Expect grant order 0001, 0010, 0100, 1000, 0001.
  - Expect exactly one ack per grant.
- Wrap and skip: ptr=3, req=4'b0101.
  - Expect grant=0001 first, then 0100.
- Spurious and withdrawn signals:
  - tx_done pulsed in IDLE and again in START → ignored; the transfer still waits for a tx_done in WAIT.
  - req dropped during WAIT → ack still pulses.
- Reset mid-WAIT:
  - All outputs are 0 on the next edge, with no ack.
  - A subsequent req=4'b0010 is granted starting from ptr=0.
- With RS232_ARB_TIMEOUT_EN and TIMEOUT=16, tx_done never arrives:
  - Expect ack and err high together for one cycle, 16 cycles after WAIT entry.
  - Expect busy low on the following cycle.
